// File: rtl/mem_controller_pkg.sv
// Shared constants and types for the LSU-side memory controller.
// Holds the access-size encodings, the read/write direction encodings, the
// start of the IO region, the controller state type and a size decoder.
package mem_controller_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [31:0] ADDR_TYPE;
    typedef logic [31:0] DATA_TYPE;

    // Direction of an LSU request (read_write_flag_from_lsu).
    localparam logic READ_SIT  = 1'b1;
    localparam logic WRITE_SIT = 1'b0;

    // Access size encodings (size_from_lsu); 2'd3 decodes as a word.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Start of the memory-mapped IO region throttled by io_buffer_full.
    localparam ADDR_TYPE IO_ADDR_BASE = 32'h0003_0000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2
    } mc_state_e;

    // Number of bytes moved for a given size encoding.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        logic [2:0] nbytes;
        case (size)
            SIZE_BYTE: nbytes = 3'd1;
            SIZE_HALF: nbytes = 3'd2;
            default:   nbytes = 3'd4;
        endcase
        return nbytes;
    endfunction

endpackage

// File: rtl/mem_controller.sv
// Responder end of the LSU <-> memory handshake. Accepts one load/store at a
// time and serialises it onto the byte-wide RAM/IO port; load bytes are
// assembled little-endian and returned with a one-cycle end pulse.
//
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (low = freeze all state)
//   enable_from_lsu, read_write_flag_from_lsu, size_from_lsu,
//   address_from_lsu, data_from_lsu       : request from the LSU
//   available_to_lsu                       : idle and able to accept
//   end_to_lsu, data_to_lsu                : completion pulse / load data
//   rollback_flag_from_rob                 : flush (aborts loads only)
//   mem_din, mem_dout, mem_a, mem_wr       : byte-wide RAM/IO port
//   io_buffer_full                         : holds off stores to the IO region
module mem_controller #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter logic [31:0] IO_ADDR_BASE = mem_controller_pkg::IO_ADDR_BASE
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              enable_from_lsu,
    input  logic              read_write_flag_from_lsu,
    input  logic [1:0]        size_from_lsu,
    input  logic [ADDR_W-1:0] address_from_lsu,
    input  logic [DATA_W-1:0] data_from_lsu,
    output logic              available_to_lsu,
    output logic              end_to_lsu,
    output logic [DATA_W-1:0] data_to_lsu,
    input  logic              rollback_flag_from_rob,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);
    import mem_controller_pkg::*;

    mc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        nbytes_q, nbytes_d;
    // Cycles spent in the current access; in READ the byte captured on a
    // given edge belongs to lane cnt_q-1 because mem_din lags mem_a.
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              end_q, end_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    logic [2:0] nxt;
    logic [1:0] lane;
    logic       io_hold;

    assign nxt  = cnt_q + 3'd1;
    assign lane = cnt_q[1:0] - 2'd1;

    // A store into the IO region must wait while the UART buffer is full.
    assign io_hold = (read_write_flag_from_lsu == WRITE_SIT) && io_buffer_full &&
                     (address_from_lsu[17:16] == IO_ADDR_BASE[17:16]);

    assign available_to_lsu = (state_q == StIdle) && !(enable_from_lsu && io_hold);
    assign end_to_lsu       = end_q;
    assign data_to_lsu      = data_out_q;
    assign mem_a            = mem_a_q;
    assign mem_dout         = mem_dout_q;
    assign mem_wr           = mem_wr_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        nbytes_d   = nbytes_q;
        cnt_d      = cnt_q;
        rbuf_d     = rbuf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        end_d      = FALSE;
        data_out_d = data_out_q;

        unique case (state_q)
            StIdle: begin
                if (enable_from_lsu && !rollback_flag_from_rob && !io_hold) begin
                    addr_d   = address_from_lsu;
                    wdata_d  = data_from_lsu[31:0];
                    nbytes_d = size_to_nbytes(size_from_lsu);
                    cnt_d    = 3'd0;
                    rbuf_d   = '0;
                    mem_a_d  = address_from_lsu;
                    if (read_write_flag_from_lsu == READ_SIT) begin
                        state_d  = StRead;
                        mem_wr_d = FALSE;
                    end else begin
                        state_d    = StWrite;
                        mem_dout_d = data_from_lsu[7:0];
                        mem_wr_d   = TRUE;
                    end
                end
            end

            StRead: begin
                if (rollback_flag_from_rob) begin
                    state_d  = StIdle;
                    mem_wr_d = FALSE;
                end else begin
                    cnt_d = nxt;
                    // Address pipeline runs one byte ahead of the capture.
                    if (nxt < nbytes_q) begin
                        mem_a_d = addr_q + ADDR_W'(nxt);
                    end
                    if (cnt_q != 3'd0) begin
                        unique case (lane)
                            2'd0: rbuf_d[7:0]   = mem_din;
                            2'd1: rbuf_d[15:8]  = mem_din;
                            2'd2: rbuf_d[23:16] = mem_din;
                            2'd3: rbuf_d[31:24] = mem_din;
                        endcase
                        if (cnt_q == nbytes_q) begin
                            end_d      = TRUE;
                            data_out_d = DATA_W'(rbuf_d);
                            state_d    = StIdle;
                        end
                    end
                end
            end

            StWrite: begin
                // Rollback is ignored here: a store that reached memory commits.
                if (nxt < nbytes_q) begin
                    mem_a_d    = addr_q + ADDR_W'(nxt);
                    mem_dout_d = wdata_q[8*nxt[1:0] +: 8];
                    mem_wr_d   = TRUE;
                    cnt_d      = nxt;
                end else begin
                    mem_wr_d = FALSE;
                    end_d    = TRUE;
                    state_d  = StIdle;
                end
            end

            default: begin
                state_d  = StIdle;
                mem_wr_d = FALSE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            nbytes_q   <= 3'd0;
            cnt_q      <= 3'd0;
            rbuf_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= FALSE;
            end_q      <= FALSE;
            data_out_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            nbytes_q   <= nbytes_d;
            cnt_q      <= cnt_d;
            rbuf_q     <= rbuf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            end_q      <= end_d;
            data_out_q <= data_out_d;
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
module tb_mem_controller;
    import mem_controller_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        enable_from_lsu;
    logic        read_write_flag_from_lsu;
    logic [1:0]  size_from_lsu;
    logic [31:0] address_from_lsu;
    logic [31:0] data_from_lsu;
    logic        available_to_lsu;
    logic        end_to_lsu;
    logic [31:0] data_to_lsu;
    logic        rollback_flag_from_rob;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    always #5 clk_in = ~clk_in;

    mem_controller dut (
        .clk_in                   (clk_in),
        .rst_in                   (rst_in),
        .rdy_in                   (rdy_in),
        .enable_from_lsu          (enable_from_lsu),
        .read_write_flag_from_lsu (read_write_flag_from_lsu),
        .size_from_lsu            (size_from_lsu),
        .address_from_lsu         (address_from_lsu),
        .data_from_lsu            (data_from_lsu),
        .available_to_lsu         (available_to_lsu),
        .end_to_lsu               (end_to_lsu),
        .data_to_lsu              (data_to_lsu),
        .rollback_flag_from_rob   (rollback_flag_from_rob),
        .mem_din                  (mem_din),
        .mem_dout                 (mem_dout),
        .mem_a                    (mem_a),
        .mem_wr                   (mem_wr),
        .io_buffer_full           (io_buffer_full)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // dev_mem is the RAM seen by the DUT; ref_mem is the reference model's view.
    logic [7:0] dev_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] dev_rd(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // Byte RAM with one cycle read latency; it shares the rdy_in stall.
    initial begin
        forever begin
            @(posedge clk_in);
            if (rdy_in) begin
                if (mem_wr) dev_mem[mem_a] = mem_dout;
                mem_din <= dev_rd(mem_a);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        dev_mem[a] = b;
        ref_mem[a] = b;
    endtask

    task automatic drive_req(input logic rw, input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] wdata);
        enable_from_lsu          = 1'b1;
        read_write_flag_from_lsu = rw;
        size_from_lsu            = sz;
        address_from_lsu         = addr;
        data_from_lsu            = wdata;
    endtask

    // One complete transaction checked against the reference model. Called at a
    // negedge with the controller idle. stall_k >= 0 holds rdy_in low for two
    // edges after the k-th post-accept sample; rb_wr holds rollback high during
    // a store, which must have no effect.
    task automatic txn(input logic rw, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wdata, input int stall_k, input bit rb_wr,
                       input string tag, output logic [31:0] got);
        int          nb, lat, k, stall_left;
        bit          fresh, done;
        logic [31:0] exp_rd, held_a;
        nb  = (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
        lat = (rw == READ_SIT) ? nb + 1 : nb;
        exp_rd = '0;
        for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = ref_rd(addr + 32'(i));
        got = '0;
        check({tag, ".avail_before"}, 32'(available_to_lsu), 32'd1);
        drive_req(rw, sz, addr, wdata);
        @(negedge clk_in);
        enable_from_lsu = 1'b0;
        if (rb_wr && rw == WRITE_SIT) rollback_flag_from_rob = 1'b1;
        k = 0; fresh = 1'b1; done = 1'b0; stall_left = 2; held_a = mem_a;
        for (int t = 0; t < 40 && !done; t++) begin
            if (fresh) begin
                if (k < nb) begin
                    check($sformatf("%s.addr%0d", tag, k), mem_a, addr + 32'(k));
                    if (rw == WRITE_SIT) begin
                        check($sformatf("%s.wr%0d", tag, k), 32'(mem_wr), 32'd1);
                        check($sformatf("%s.dout%0d", tag, k), 32'(mem_dout),
                              32'(wdata[8*k +: 8]));
                    end else begin
                        check($sformatf("%s.rd_wr%0d", tag, k), 32'(mem_wr), 32'd0);
                    end
                end
                if (end_to_lsu) begin
                    check({tag, ".latency"}, 32'(k), 32'(lat));
                    got  = data_to_lsu;
                    done = 1'b1;
                    if (rw == READ_SIT) check({tag, ".data"}, data_to_lsu, exp_rd);
                    else check({tag, ".wr_off"}, 32'(mem_wr), 32'd0);
                end else if (k >= lat) begin
                    check({tag, ".end_missing"}, 32'(end_to_lsu), 32'd1);
                    done = 1'b1;
                end
                held_a = mem_a;
            end else begin
                check({tag, ".stall_hold"}, mem_a, held_a);
            end
            if (!done) begin
                if (k == stall_k && stall_left > 0) begin
                    rdy_in = 1'b0; stall_left--; fresh = 1'b0;
                end else begin
                    rdy_in = 1'b1; k++; fresh = 1'b1;
                end
                @(negedge clk_in);
            end
        end
        rdy_in = 1'b1;
        rollback_flag_from_rob = 1'b0;
        if (!done) check({tag, ".timeout"}, 32'(end_to_lsu), 32'd1);
        @(negedge clk_in);
        check({tag, ".single_pulse"}, 32'(end_to_lsu), 32'd0);
        check({tag, ".avail_after"}, 32'(available_to_lsu), 32'd1);
        if (rw == WRITE_SIT) begin
            for (int i = 0; i < nb; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
        end
    endtask

    typedef struct packed {
        logic        rw;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] got;
    int          ends;

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; enable_from_lsu = 1'b0;
        read_write_flag_from_lsu = READ_SIT; size_from_lsu = SIZE_BYTE;
        address_from_lsu = '0; data_from_lsu = '0;
        rollback_flag_from_rob = 1'b0; io_buffer_full = 1'b0;

        preload(32'h0000_1000, 8'h11); preload(32'h0000_1001, 8'h22);
        preload(32'h0000_1002, 8'h33); preload(32'h0000_1003, 8'h44);
        preload(32'h0000_1004, 8'h55); preload(32'h0000_1005, 8'h66);
        preload(32'hFFFF_FFFF, 8'h80); preload(32'h0000_0000, 8'h5C);
        preload(32'h0000_0200, 8'h01); preload(32'h0000_0201, 8'h02);

        // Reset state
        repeat (2) @(negedge clk_in);
        check("reset.mem_wr", 32'(mem_wr), 32'd0);
        check("reset.mem_a", mem_a, 32'd0);
        check("reset.mem_dout", 32'(mem_dout), 32'd0);
        check("reset.end", 32'(end_to_lsu), 32'd0);
        check("reset.data", data_to_lsu, 32'd0);
        check("reset.avail", 32'(available_to_lsu), 32'd1);
        rst_in = 1'b1;
        @(negedge clk_in);

        // Directed vectors: {rw, size, addr, store data, expected load data}
        vecs[0] = '{READ_SIT,  SIZE_WORD, 32'h0000_1000, 32'h0,         32'h4433_2211};
        vecs[1] = '{WRITE_SIT, SIZE_HALF, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{READ_SIT,  SIZE_WORD, 32'h0000_0200, 32'h0,         32'hBEEF_0201};
        vecs[3] = '{READ_SIT,  SIZE_BYTE, 32'hFFFF_FFFF, 32'h0,         32'h0000_0080};
        vecs[4] = '{READ_SIT,  SIZE_HALF, 32'hFFFF_FFFF, 32'h0,         32'h0000_5C80};
        vecs[5] = '{WRITE_SIT, SIZE_BYTE, 32'h0000_1001, 32'h1234_56AA, 32'h0};
        vecs[6] = '{READ_SIT,  2'd3,      32'h0000_1000, 32'h0,         32'h4433_AA11};
        vecs[7] = '{READ_SIT,  SIZE_WORD, 32'h0000_1002, 32'h0,         32'h6655_4433};
        vecs[8] = '{WRITE_SIT, SIZE_WORD, 32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0};
        vecs[9] = '{READ_SIT,  SIZE_HALF, 32'hFFFF_FFFF, 32'h0,         32'h0000_FEF0};
        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].rw, vecs[i].sz, vecs[i].addr, vecs[i].wdata, -1, 1'b0,
                $sformatf("vec%0d", i), got);
            if (vecs[i].rw == READ_SIT) check($sformatf("vec%0d.table", i), got, vecs[i].exp);
        end

        // Rollback on cycle +2 of a word load: no end pulse, idle next cycle.
        drive_req(READ_SIT, SIZE_WORD, 32'h0000_1000, 32'h0);
        @(negedge clk_in); enable_from_lsu = 1'b0;
        @(negedge clk_in); rollback_flag_from_rob = 1'b1;
        @(negedge clk_in); rollback_flag_from_rob = 1'b0;
        check("rb_lw.end", 32'(end_to_lsu), 32'd0);
        check("rb_lw.avail", 32'(available_to_lsu), 32'd1);
        check("rb_lw.wr", 32'(mem_wr), 32'd0);
        ends = 0;
        repeat (6) begin @(negedge clk_in); ends += int'(end_to_lsu); end
        check("rb_lw.no_pulse", 32'(ends), 32'd0);
        txn(WRITE_SIT, SIZE_BYTE, 32'h0000_1003, 32'h0000_0077, -1, 1'b0, "rb_sb", got);

        // Rollback coinciding with the final byte of a byte load wins.
        drive_req(READ_SIT, SIZE_BYTE, 32'h0000_1000, 32'h0);
        @(negedge clk_in); enable_from_lsu = 1'b0; rollback_flag_from_rob = 1'b1;
        @(negedge clk_in); rollback_flag_from_rob = 1'b0;
        check("rb_last.end", 32'(end_to_lsu), 32'd0);
        check("rb_last.avail", 32'(available_to_lsu), 32'd1);
        @(negedge clk_in);
        check("rb_last.late_end", 32'(end_to_lsu), 32'd0);

        // Rollback in idle drops a same-cycle store request.
        drive_req(WRITE_SIT, SIZE_BYTE, 32'h0000_1000, 32'h0000_0099);
        rollback_flag_from_rob = 1'b1;
        @(negedge clk_in); enable_from_lsu = 1'b0; rollback_flag_from_rob = 1'b0;
        check("rb_idle.wr", 32'(mem_wr), 32'd0);
        check("rb_idle.avail", 32'(available_to_lsu), 32'd1);
        @(negedge clk_in);
        txn(READ_SIT, SIZE_WORD, 32'h0000_1000, 32'h0, -1, 1'b0, "rb_readback", got);
        check("rb_readback.table", got, 32'h7733_AA11);

        // Rollback during a store is ignored.
        txn(WRITE_SIT, SIZE_WORD, 32'h0000_2200, 32'hA1B2_C3D4, -1, 1'b1, "rb_sw", got);
        txn(READ_SIT, SIZE_WORD, 32'h0000_2200, 32'h0, -1, 1'b0, "rb_sw_rd", got);
        check("rb_sw_rd.table", got, 32'hA1B2_C3D4);

        // IO throttle: store to the IO region waits while the buffer is full.
        io_buffer_full = 1'b1;
        drive_req(WRITE_SIT, SIZE_BYTE, 32'h0003_0000, 32'h0000_005A);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check($sformatf("io.held_wr%0d", i), 32'(mem_wr), 32'd0);
            check($sformatf("io.held_avail%0d", i), 32'(available_to_lsu), 32'd0);
        end
        io_buffer_full = 1'b0;
        @(negedge clk_in); enable_from_lsu = 1'b0;
        check("io.issue_wr", 32'(mem_wr), 32'd1);
        check("io.issue_a", mem_a, 32'h0003_0000);
        check("io.issue_dout", 32'(mem_dout), 32'h5A);
        check("io.issue_end", 32'(end_to_lsu), 32'd0);
        @(negedge clk_in);
        check("io.end", 32'(end_to_lsu), 32'd1);
        check("io.wr_off", 32'(mem_wr), 32'd0);
        ref_mem[32'h0003_0000] = 8'h5A;
        @(negedge clk_in);
        // Loads from the IO region are not throttled.
        io_buffer_full = 1'b1;
        txn(READ_SIT, SIZE_BYTE, 32'h0003_0000, 32'h0, -1, 1'b0, "io_lb", got);
        check("io_lb.table", got, 32'h0000_005A);
        io_buffer_full = 1'b0;

        // Reset in the middle of a word store, after two bytes.
        drive_req(WRITE_SIT, SIZE_WORD, 32'h0000_2100, 32'h1122_3344);
        @(negedge clk_in); enable_from_lsu = 1'b0;
        @(negedge clk_in); rst_in = 1'b0;
        @(negedge clk_in); rst_in = 1'b1;
        check("rst_mid.wr", 32'(mem_wr), 32'd0);
        check("rst_mid.end", 32'(end_to_lsu), 32'd0);
        check("rst_mid.avail", 32'(available_to_lsu), 32'd1);
        check("rst_mid.a", mem_a, 32'd0);
        check("rst_mid.data", data_to_lsu, 32'd0);
        ref_mem[32'h0000_2100] = 8'h44;
        ref_mem[32'h0000_2101] = 8'h33;
        txn(READ_SIT, SIZE_WORD, 32'h0000_2100, 32'h0, -1, 1'b0, "rst_rd", got);

        // rdy_in low for two cycles in the middle of a word load.
        txn(READ_SIT, SIZE_WORD, 32'h0000_1000, 32'h0, 2, 1'b0, "stall_lw", got);
        check("stall_lw.table", got, 32'h7733_AA11);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic        rw;
            logic [1:0]  sz;
            logic [31:0] addr;
            int          win, stall_k;
            rw  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            win = int'($urandom_range(0, 2));
            if (win == 0)      addr = 32'h0000_2000 + 32'($urandom_range(0, 63));
            else if (win == 1) addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else               addr = 32'h0000_1000 + 32'($urandom_range(0, 7));
            stall_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            txn(rw, sz, addr, $urandom, stall_k, 1'($urandom_range(0, 1)),
                $sformatf("rnd%0d", n), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
